// File: rtl/countdown_sequencer.sv
// Countdown timer sequencer: prescaled step tick, two-digit BCD down-counter and
// idle/run/pause/alarm control for the 7-segment display and buzzer. All outputs are registered.
module countdown_sequencer #(
  parameter int unsigned TICK_DIV    = 50_000_000,
  parameter int unsigned BEEP_TICKS  = 3,
  parameter logic [7:0]  DEFAULT_BCD = 8'h15
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic       load,
  input  logic [7:0] preset,
  output logic [3:0] TimeH,
  output logic [3:0] TimeL,
  output logic       tick,
  output logic       running,
  output logic       expired,
  output logic       beep
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam int unsigned BW = $clog2(BEEP_TICKS + 1);
  localparam logic [PW-1:0] PresLast = PW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BeepLast = BW'(BEEP_TICKS);

  // Encoding chosen so running/expired are plain state register bits.
  typedef enum logic [2:0] {
    StIdle  = 3'b000,
    StRun   = 3'b001,
    StAlarm = 3'b010,
    StPause = 3'b100
  } state_e;

  state_e        state_q;
  logic [7:0]    count_q;
  logic [7:0]    reload_q;
  logic [PW-1:0] presc_q;
  logic [BW-1:0] beep_cnt_q;
  logic          tick_q;
  logic          beep_q;

  logic          preset_ok;
  logic          counting;
  logic          terminal;
  logic [7:0]    count_dec;
  logic [PW-1:0] presc_inc;
  logic [BW-1:0] beep_inc;

  always_comb begin
    preset_ok = (preset[7:4] <= 4'd9) && (preset[3:0] <= 4'd9);
    counting  = (state_q == StRun) || (state_q == StAlarm);
    terminal  = counting && (presc_q == PresLast);
    presc_inc = presc_q + PW'(1);
    beep_inc  = beep_cnt_q + BW'(1);
    if (count_q == 8'h00) begin
      count_dec = 8'h00;
    end else if (count_q[3:0] == 4'd0) begin
      count_dec = {count_q[7:4] - 4'd1, 4'd9};
    end else begin
      count_dec = {count_q[7:4], count_q[3:0] - 4'd1};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      count_q    <= DEFAULT_BCD;
      reload_q   <= DEFAULT_BCD;
      presc_q    <= '0;
      beep_cnt_q <= '0;
      tick_q     <= 1'b0;
      beep_q     <= 1'b0;
    end else begin
      tick_q <= terminal;
      if (counting) begin
        presc_q <= terminal ? '0 : presc_inc;
      end

      unique case (state_q)
        StIdle: begin
          if (load && preset_ok) begin
            count_q  <= preset;
            reload_q <= preset;
          end else if (start && (count_q != 8'h00)) begin
            state_q <= StRun;
            presc_q <= '0;
          end
        end

        StRun: begin
          if (terminal) begin
            count_q <= count_dec;
          end
          // Reaching zero wins over a coincident pause.
          if (terminal && (count_dec == 8'h00)) begin
            state_q    <= StAlarm;
            beep_q     <= 1'b1;
            beep_cnt_q <= '0;
          end else if (pause) begin
            state_q <= StPause;
          end
        end

        StPause: begin
          if (load && preset_ok) begin
            count_q  <= preset;
            reload_q <= preset;
            state_q  <= StIdle;
            presc_q  <= '0;
          end else if (start || pause) begin
            state_q <= StRun;
          end
        end

        StAlarm: begin
          if (load && preset_ok) begin
            count_q  <= preset;
            reload_q <= preset;
            state_q  <= StIdle;
            beep_q   <= 1'b0;
            presc_q  <= '0;
          end else if (start) begin
            count_q <= reload_q;
            state_q <= StRun;
            beep_q  <= 1'b0;
            presc_q <= '0;
          end else if (terminal && beep_q) begin
            beep_cnt_q <= beep_inc;
            if (beep_inc == BeepLast) begin
              beep_q <= 1'b0;
            end
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  assign TimeH   = count_q[7:4];
  assign TimeL   = count_q[3:0];
  assign tick    = tick_q;
  assign running = state_q[0];
  assign expired = state_q[1];
  assign beep    = beep_q;

endmodule
